// File: rtl/riscp_pkg.sv
// riscp_pkg: widths, reset/vector addresses and the fetch FSM state encoding
// shared by the fetch stage of the 16-bit RISC core.
package riscp_pkg;

  localparam int              PC_W       = 12;
  localparam int              IR_W       = 16;
  localparam logic [PC_W-1:0] RESET_PC   = 12'h000;
  localparam logic [PC_W-1:0] IRQ_VECTOR = 12'h001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_return_stack.sv
// return_stack: circular LIFO of return addresses.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, push_adr  write push_adr on top (overwrites oldest entry when full)
//   pop             discard the top entry (no movement when empty)
//   top             current top entry, 0 when empty
//   overflow        sticky: a push happened while full
//   underflow       sticky: a pop happened while empty
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_adr,
  input  logic         pop,
  output logic [W-1:0] top,
  output logic         overflow,
  output logic         underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;    // next free slot; wraps so a full push overwrites the oldest
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign top   = empty ? '0 : mem[ptr - 1'b1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[ptr] <= push_adr;
      ptr      <= ptr + 1'b1;
      if (full) overflow <= 1'b1;
      else      count    <= count + 1'b1;
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        ptr   <= ptr - 1'b1;
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Runs req/ack fetches from instruction
// memory into a single-entry IR slot, redirects on branch / interrupt / RTI,
// and owns IE, EPC and the subroutine return stack.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_req/adr/ack/data            instruction memory handshake
//   IR, PC, IR_valid                 instruction slot presented to decode
//   RTS_adr                          top of return stack
//   stall_d                          decode not accepting
//   branch_taken, branch_target      redirect for the instruction consumed
//   subroutine_call_d/return_d, IEN_d, IOF_d, RTI_d   decoder controls
//   irq                              level interrupt request
//   stk_overflow, stk_underflow      sticky stack error flags
//
// state | meaning
// IDLE  | in reset; leaves on the first clock after release
// FETCH | normal fetch; request whenever the IR slot is free or being consumed
// FLUSH | a redirected-away request is still pending; drop its data on ack
module fetch_unit
  #(
  parameter int              PC_W        = riscp_pkg::PC_W,
  parameter int              IR_W        = riscp_pkg::IR_W,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC    = riscp_pkg::RESET_PC,
  parameter logic [PC_W-1:0] IRQ_VECTOR  = riscp_pkg::IRQ_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_adr,
  input  logic            imem_ack,
  input  logic [IR_W-1:0] imem_data,
  output logic [IR_W-1:0] IR,
  output logic [PC_W-1:0] PC,
  output logic            IR_valid,
  output logic [PC_W-1:0] RTS_adr,
  input  logic            stall_d,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            subroutine_call_d,
  input  logic            subroutine_return_d,
  input  logic            IEN_d,
  input  logic            IOF_d,
  input  logic            RTI_d,
  input  logic            irq,
  output logic            stk_overflow,
  output logic            stk_underflow
);

  import riscp_pkg::*;

  fetch_state_e    state;
  logic [PC_W-1:0] fetch_adr;
  logic [PC_W-1:0] flush_adr;   // address of the abandoned request, held while it drains
  logic [PC_W-1:0] epc;
  logic            ie;

  logic            irq_take;
  logic            consume;
  logic            redirect;
  logic [PC_W-1:0] redirect_adr;
  logic            load;

  // A taken interrupt squashes IR instead of consuming it, so it re-executes after RTI.
  assign irq_take = irq & ie & IR_valid & ~stall_d & ~branch_taken;
  assign consume  = IR_valid & ~stall_d & ~irq_take;
  assign redirect = (consume & branch_taken) | irq_take | (consume & RTI_d);

  always_comb begin
    redirect_adr = epc;
    if (irq_take)               redirect_adr = IRQ_VECTOR;
    if (consume & branch_taken) redirect_adr = branch_target;
  end

  always_comb begin
    imem_req = 1'b0;
    case (state)
      ST_FETCH: imem_req = ~IR_valid | consume;
      ST_FLUSH: imem_req = 1'b1;
      default:  imem_req = 1'b0;
    endcase
  end

  assign imem_adr = (state == ST_FLUSH) ? flush_adr : fetch_adr;
  assign load     = (state == ST_FETCH) & imem_req & imem_ack & ~redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fetch_adr <= RESET_PC;
      flush_adr <= RESET_PC;
      IR        <= '0;
      PC        <= '0;
      IR_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_FETCH;
          fetch_adr <= RESET_PC;
        end
        ST_FETCH: begin
          if (redirect) begin
            IR_valid  <= 1'b0;
            fetch_adr <= redirect_adr;
            if (imem_req & ~imem_ack) begin
              state     <= ST_FLUSH;
              flush_adr <= fetch_adr;
            end
          end else if (load) begin
            IR        <= imem_data;
            PC        <= fetch_adr;
            IR_valid  <= 1'b1;
            fetch_adr <= fetch_adr + 1'b1;
          end else if (consume) begin
            IR_valid <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (imem_ack) state <= ST_FETCH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie  <= 1'b0;
      epc <= '0;
    end else if (irq_take) begin
      ie  <= 1'b0;
      epc <= PC;
    end else if (consume) begin
      if (IEN_d | RTI_d) ie <= 1'b1;
      else if (IOF_d)    ie <= 1'b0;
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_return_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (consume & subroutine_call_d),
    .push_adr  (PC + 1'b1),
    .pop       (consume & subroutine_return_d),
    .top       (RTS_adr),
    .overflow  (stk_overflow),
    .underflow (stk_underflow)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [11:0] imem_adr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] IR;
  logic [11:0] PC;
  logic        IR_valid;
  logic [11:0] RTS_adr;
  logic        stall_d = 1'b0;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_target = '0;
  logic        subroutine_call_d = 1'b0;
  logic        subroutine_return_d = 1'b0;
  logic        IEN_d = 1'b0;
  logic        IOF_d = 1'b0;
  logic        RTI_d = 1'b0;
  logic        irq = 1'b0;
  logic        stk_overflow;
  logic        stk_underflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [11:0] pc;
    logic [15:0] ir;
  } exp_t;
  exp_t sb[$];

  fetch_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .imem_req            (imem_req),
    .imem_adr            (imem_adr),
    .imem_ack            (imem_ack),
    .imem_data           (imem_data),
    .IR                  (IR),
    .PC                  (PC),
    .IR_valid            (IR_valid),
    .RTS_adr             (RTS_adr),
    .stall_d             (stall_d),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .subroutine_call_d   (subroutine_call_d),
    .subroutine_return_d (subroutine_return_d),
    .IEN_d               (IEN_d),
    .IOF_d               (IOF_d),
    .RTI_d               (RTI_d),
    .irq                 (irq),
    .stk_overflow        (stk_overflow),
    .stk_underflow       (stk_underflow)
  );

  always #5 clk = ~clk;

  // Memory model: word = address, except one marker word; ack after lat wait cycles.
  int lat = 0;
  int wait_cnt = 0;

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    return (a == 12'h034) ? 16'h1234 : {4'h0, a};
  endfunction

  always_comb begin
    imem_ack  = imem_req && (wait_cnt >= lat);
    imem_data = mem_word(imem_adr);
  end

  always_ff @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_pc(input logic [11:0] pc);
    exp_t e;
    e.pc = pc;
    e.ir = mem_word(pc);
    sb.push_back(e);
  endtask

  // Wait (bounded) for a live IR and compare it against the scoreboard head.
  task automatic check_next(input string tag);
    exp_t e;
    for (int i = 0; i < 20 && !IR_valid; i++) @(negedge clk);
    check({tag, "_valid"}, {15'b0, IR_valid}, 16'h0001);
    e = sb.pop_front();
    check({tag, "_pc"}, {4'h0, PC}, {4'h0, e.pc});
    check({tag, "_ir"}, IR, e.ir);
  endtask

  // Apply decoder outputs for the current IR for one clock, then clear them.
  task automatic decode(input logic br, input logic [11:0] tgt, input logic call,
                        input logic ret, input logic ien, input logic rti);
    branch_taken        = br;
    branch_target       = tgt;
    subroutine_call_d   = call;
    subroutine_return_d = ret;
    IEN_d               = ien;
    RTI_d               = rti;
    @(negedge clk);
    branch_taken        = 1'b0;
    branch_target       = '0;
    subroutine_call_d   = 1'b0;
    subroutine_return_d = 1'b0;
    IEN_d               = 1'b0;
    RTI_d               = 1'b0;
  endtask

  initial begin
    logic [11:0] exp_rts;

    repeat (2) @(negedge clk);
    check("rst_req",   {15'b0, imem_req}, 16'h0000);
    check("rst_adr",   {4'h0, imem_adr},  16'h0000);
    check("rst_ir",    IR,                16'h0000);
    check("rst_pc",    {4'h0, PC},        16'h0000);
    check("rst_valid", {15'b0, IR_valid}, 16'h0000);
    check("rst_rts",   {4'h0, RTS_adr},   16'h0000);
    check("rst_ovf",   {15'b0, stk_overflow},  16'h0000);
    check("rst_unf",   {15'b0, stk_underflow}, 16'h0000);

    rst_n = 1'b1;
    check("idle_req", {15'b0, imem_req}, 16'h0000);
    @(negedge clk);
    check("first_req", {15'b0, imem_req}, 16'h0001);
    check("first_adr", {4'h0, imem_adr},  16'h0000);

    // Zero-wait sequential fetch
    for (int a = 0; a < 4; a++) expect_pc(12'(a));
    for (int a = 0; a < 3; a++) begin
      check_next("seq");
      decode(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_next("seq3");
    expect_pc(12'h034);
    decode(1'b1, 12'h034, 1'b0, 1'b0, 1'b0, 1'b0);
    check("br_gap", {15'b0, IR_valid}, 16'h0000);
    check_next("br034");

    // Stall
    stall_d = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_ir",  IR,                16'h1234);
      check("stall_pc",  {4'h0, PC},        16'h0034);
      check("stall_req", {15'b0, imem_req}, 16'h0000);
    end
    expect_pc(12'h035);
    stall_d = 1'b0;
    @(negedge clk);
    check_next("unstall");

    // Calls: nine pushes into a depth-8 stack
    expect_pc(12'h010);
    decode(1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0);
    check_next("br010");
    for (int k = 0; k < 9; k++) begin
      expect_pc(12'h011 + 12'(k));
      decode(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rts_push", {4'h0, RTS_adr}, {4'h0, 12'h011 + 12'(k)});
      if (k == 7) check("ovf_full", {15'b0, stk_overflow}, 16'h0000);
      if (k == 8) check("ovf_set",  {15'b0, stk_overflow}, 16'h0001);
      check_next("call_seq");
    end

    // Returns: eight live entries then one pop on empty
    for (int k = 0; k < 9; k++) begin
      expect_pc(12'h01A + 12'(k));
      decode(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_rts = (k < 7) ? 12'h018 - 12'(k) : 12'h000;
      check("rts_pop", {4'h0, RTS_adr}, {4'h0, exp_rts});
      if (k == 7) check("unf_clear", {15'b0, stk_underflow}, 16'h0000);
      if (k == 8) check("unf_set",   {15'b0, stk_underflow}, 16'h0001);
      check_next("ret_seq");
    end

    // Interrupt entry and RTI
    expect_pc(12'h040);
    decode(1'b1, 12'h040, 1'b0, 1'b0, 1'b1, 1'b0);
    check_next("ion040");
    expect_pc(12'h001);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    check("irq_gap", {15'b0, IR_valid}, 16'h0000);
    check("irq_adr", {4'h0, imem_adr},  16'h0001);
    check_next("irq_vec");
    expect_pc(12'h002);
    decode(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_next("isr_seq");
    irq = 1'b1;
    expect_pc(12'h003);
    decode(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    irq = 1'b0;
    check_next("ie_off");
    expect_pc(12'h040);
    decode(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rti_gap", {15'b0, IR_valid}, 16'h0000);
    check("rti_adr", {4'h0, imem_adr},  16'h0040);
    check_next("rti_ret");

    // Branch beats interrupt; interrupt taken on the next live instruction
    irq = 1'b1;
    expect_pc(12'h100);
    decode(1'b1, 12'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    check_next("prio_br");
    expect_pc(12'h001);
    @(negedge clk);
    check("prio_gap", {15'b0, IR_valid}, 16'h0000);
    irq = 1'b0;
    check_next("prio_irq");

    // Two-cycle memory: branch with a request outstanding
    lat = 1;
    expect_pc(12'h002);
    decode(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lat_gap", {15'b0, IR_valid}, 16'h0000);
    check_next("lat_seq");
    expect_pc(12'h200);
    decode(1'b1, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    check("flush_req", {15'b0, imem_req}, 16'h0001);
    check("flush_adr", {4'h0, imem_adr},  16'h0003);
    check("flush_val", {15'b0, IR_valid}, 16'h0000);
    @(negedge clk);
    check("post_flush_adr", {4'h0, imem_adr},  16'h0200);
    check("post_flush_val", {15'b0, IR_valid}, 16'h0000);
    check_next("flush_tgt");

    // Address wrap at zero-wait
    lat = 0;
    expect_pc(12'hFFE);
    decode(1'b1, 12'hFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    check_next("wrap_ffe");
    expect_pc(12'hFFF);
    decode(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_next("wrap_fff");
    check("wrap_adr", {4'h0, imem_adr}, 16'h0000);
    expect_pc(12'h000);
    decode(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_next("wrap_000");

    // Async reset with a request pending
    lat = 1;
    decode(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pend_req", {15'b0, imem_req}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req",   {15'b0, imem_req}, 16'h0000);
    check("arst_valid", {15'b0, IR_valid}, 16'h0000);
    check("arst_adr",   {4'h0, imem_adr},  16'h0000);
    check("arst_ovf",   {15'b0, stk_overflow}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit RISC processor: the producer side of the decode interface. It drives `IR`, `PC` and `RTS_adr` into the decode stage and consumes the decoder's control outputs back. It runs a request/acknowledge fetch from instruction memory, holds the single-entry IR slot under stall, redirects on taken branches, owns the subroutine return-address stack and performs interrupt entry and RTI.

## Interface
- `PC_W`, 12, program counter / instruction address width
- `IR_W`, 16, instruction width
- `STACK_DEPTH`, 8, return-stack entries (power of two)
- `RESET_PC`, 12'h000, first fetch address after reset
- `IRQ_VECTOR`, 12'h001, interrupt handler address

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `imem_req` out 1: fetch request
- `imem_adr` out PC_W: fetch address, stable while `imem_req` is high and not yet acked
- `imem_ack` in 1: data valid this cycle
- `imem_data` in IR_W: instruction word
- `IR` out IR_W: instruction to decode
- `PC` out PC_W: address of `IR`
- `IR_valid` out 1: IR slot holds a live instruction
- `RTS_adr` out PC_W: top of return stack, combinational
- `stall_d` in 1: downstream not accepting
- `branch_taken` in 1, `branch_target` in PC_W: redirect for the instruction being consumed this cycle
- `subroutine_call_d`, `subroutine_return_d`, `IEN_d`, `IOF_d`, `RTI_d` in 1: decoder outputs for the current `IR`
- `irq` in 1: level interrupt request
- `stk_overflow`, `stk_underflow` out 1: sticky error flags

## Operation
- **Consume:** `consume = IR_valid & !stall_d & !irq_take`. Decoder inputs act only on consume.
- **FSM states:**
  - IDLE: reset only. Moves to FETCH on the first clock after reset release, with `fetch_adr = RESET_PC`.
  - FETCH: `imem_req = !IR_valid | consume`.
  - FLUSH: a request is outstanding and its data must be discarded. `imem_req` stays high until ack; no IR load. Then FETCH.
- **Ack in FETCH (no redirect):** `IR <= imem_data`, `PC <= fetch_adr`, `IR_valid <= 1`, `fetch_adr <= fetch_adr + 1`. The increment wraps mod 2^PC_W.
- **Consume with no ack:** `IR_valid <= 0`.
- **Redirect sources, priority high to low:** `branch_taken` on consume, then `irq_take`, then `RTI_d` on consume.
  - On redirect: `IR_valid <= 0`, `fetch_adr <=` target.
  - If `imem_req` is high with no ack this cycle, go to FLUSH.
  - Any ack in the redirect cycle is discarded.
- **Interrupt:** `irq_take = irq & IE & IR_valid & !stall_d & !branch_taken`.
  - Effect: `EPC <= PC`. The IR instruction is squashed, not consumed, and re-executes after RTI.
  - Also `IE <= 0`, target `IRQ_VECTOR`.
  - `irq` blocked by `branch_taken` is re-evaluated next valid cycle.
- **IE control:**
  - `IEN_d` consumed sets IE; `IOF_d` consumed clears IE.
  - `RTI_d` consumed sets IE, target `EPC`.
- **Return stack:**
  - `subroutine_call_d` consumed pushes `PC + 1`.
  - `subroutine_return_d` consumed pops. The execute stage supplies `branch_taken`/`branch_target` for BSR/RTS.
  - Push when full: overwrite the oldest entry (circular), set `stk_overflow`.
  - Pop when empty: pointer unchanged, `RTS_adr` = 0, set `stk_underflow`.
  - Flags clear only on reset.

## Timing
- **Reset values:** `imem_req` 0, `imem_adr` = `RESET_PC`, `IR` 0, `PC` 0, `IR_valid` 0, `RTS_adr` 0, flags 0, IE 0, EPC 0, stack empty.
- **Fetch latency:** the first `imem_req` is in cycle 1 after `rst_n` rises. `IR_valid` rises the cycle after ack. With zero-wait memory (ack in the request cycle), sustained rate is 1 instruction/cycle.
- **Stall:** while `IR_valid & stall_d`, `IR`/`PC` hold and `imem_req` is 0 (a previously issued request, if un-acked, stays asserted).
- **Redirect:** the target request is issued the cycle after redirect, or the cycle after the flushed ack. `IR_valid` is 0 for at least one cycle.
- **Stack updates:** take effect at the clock edge. `RTS_adr` reflects the new top the next cycle.
- **Async reset mid-request:** `imem_req` drops immediately; memory must tolerate an abandoned request.

## Structure
- **Shared package `riscp_pkg`:** `PC_W`, `IR_W`, `RESET_PC`, `IRQ_VECTOR`, fetch state enum (IDLE, FETCH, FLUSH).
- **Sub-module `return_stack`:** circular LIFO with push, pop, top, overflow and underflow flags. The FSM, IR slot, IE/EPC and redirect logic stay in `fetch_unit`.

## Test plan
- **Zero-wait sequential fetch:** reset, ack every cycle, memory = address → `IR`=0,1,2… on consecutive cycles, `PC` matching, `imem_adr` wraps 12'hFFF→12'h000.
- **Stall:** `stall_d` high 3 cycles with `IR`=0x1234 → `IR`/`PC` constant, `imem_req` 0; release → next word loaded the following cycle.
- **Branch during outstanding request (2-cycle memory latency):** `branch_taken` with target 0x200 → FLUSH, stale ack discarded, next `IR_valid` has `PC`=0x200.
- **Call/return:** BSR consumed at `PC`=0x010 → `RTS_adr`=0x011 next cycle. Nine pushes with depth 8 → `stk_overflow`=1. Pop on empty → `stk_underflow`=1, `RTS_adr`=0.
- **Interrupt:** ION consumed, `irq`=1 while `IR` at 0x040 → `EPC`=0x040, IE=0, next fetch 0x001. RTI consumed → fetch 0x040, IE=1.
- **Priority:** `irq` and `branch_taken` in the same cycle → branch to target first, interrupt taken on the next valid instruction.
